// File: rtl/input_unit.sv
// Calculator keypad front end: edge-detected keys build a signed decimal entry, committed as 8-bit two's complement.
// Optional macro INPUT_UNIT_AUTOLOAD_EN: the digit that fills the entry also triggers the load range check.
module input_unit #(
    parameter int MAX_DIGITS = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DIGIT,
    input  logic       KEY_ENTER,
    input  logic       KEY_NEG,
    input  logic       KEY_LOAD,
    input  logic       KEY_CLEAR,
    output logic [7:0] TC,
    output logic       VALID,
    output logic       ERR,
    output logic [9:0] MAG,
    output logic       NEG,
    output logic [1:0] DIGIT_CNT,
    output logic [1:0] STATE_DBG
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ENTRY   = 2'd1,
        S_CONVERT = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

    state_t     state_q, state_d;
    logic [7:0] tc_q, tc_d;
    logic       valid_q, valid_d;
    logic [9:0] mag_q, mag_d;
    logic       neg_q, neg_d;
    logic [1:0] cnt_q, cnt_d;
    logic       enter_prev_q, neg_prev_q, load_prev_q, clear_prev_q;

    logic       e_enter, e_neg, e_load, e_clear;
    logic       digit_ok;
    logic [9:0] mag_next;

    // A negative entry may reach one further than a positive one (-128).
    function automatic logic in_range(input logic [9:0] m, input logic n);
        return n ? (m <= 10'd128) : (m <= 10'd127);
    endfunction

    assign e_enter  = KEY_ENTER & ~enter_prev_q;
    assign e_neg    = KEY_NEG & ~neg_prev_q;
    assign e_load   = KEY_LOAD & ~load_prev_q;
    assign e_clear  = KEY_CLEAR & ~clear_prev_q;
    assign digit_ok = (DIGIT <= 4'd9);
    assign mag_next = (mag_q << 3) + (mag_q << 1) + {6'd0, DIGIT};

    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        valid_d = 1'b0;
        mag_d   = mag_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (e_clear) begin
                    mag_d = '0;
                    neg_d = 1'b0;
                    cnt_d = '0;
                end else if (e_load) begin
                    state_d = S_CONVERT;
                end else if (e_enter) begin
                    if (digit_ok) begin
                        mag_d   = {6'd0, DIGIT};
                        cnt_d   = 2'd1;
                        state_d = S_ENTRY;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else if (e_neg) begin
                    neg_d   = ~neg_q;
                    state_d = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (e_clear) begin
                    mag_d   = '0;
                    neg_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (e_load) begin
                    state_d = in_range(mag_q, neg_q) ? S_CONVERT : S_ERROR;
                end else if (e_enter) begin
                    // A full entry swallows further digits, even illegal ones.
                    if (cnt_q < MAX_CNT) begin
                        if (digit_ok) begin
                            mag_d = mag_next;
                            cnt_d = cnt_q + 2'd1;
`ifdef INPUT_UNIT_AUTOLOAD_EN
                            if (cnt_q + 2'd1 == MAX_CNT)
                                state_d = in_range(mag_next, neg_q) ? S_CONVERT : S_ERROR;
`endif
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
                end else if (e_neg) begin
                    neg_d = ~neg_q;
                end
            end
            S_CONVERT: begin
                tc_d    = neg_q ? (~mag_q[7:0] + 8'd1) : mag_q[7:0];
                valid_d = 1'b1;
                mag_d   = '0;
                neg_d   = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                if (e_clear) begin
                    mag_d   = '0;
                    neg_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            tc_q         <= '0;
            valid_q      <= 1'b0;
            mag_q        <= '0;
            neg_q        <= 1'b0;
            cnt_q        <= '0;
            enter_prev_q <= 1'b0;
            neg_prev_q   <= 1'b0;
            load_prev_q  <= 1'b0;
            clear_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tc_q         <= tc_d;
            valid_q      <= valid_d;
            mag_q        <= mag_d;
            neg_q        <= neg_d;
            cnt_q        <= cnt_d;
            enter_prev_q <= KEY_ENTER;
            neg_prev_q   <= KEY_NEG;
            load_prev_q  <= KEY_LOAD;
            clear_prev_q <= KEY_CLEAR;
        end
    end

    assign TC        = tc_q;
    assign VALID     = valid_q;
    assign ERR       = (state_q == S_ERROR);
    assign MAG       = mag_q;
    assign NEG       = neg_q;
    assign DIGIT_CNT = cnt_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_input_unit.sv
// Directed bench for input_unit: key sequences with hand-computed operands, errors and key priority.
module tb_input_unit;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ERROR = 2'd3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] DIGIT = 4'd0;
    logic       KEY_ENTER = 1'b0;
    logic       KEY_NEG = 1'b0;
    logic       KEY_LOAD = 1'b0;
    logic       KEY_CLEAR = 1'b0;
    logic [7:0] TC;
    logic       VALID;
    logic       ERR;
    logic [9:0] MAG;
    logic       NEG;
    logic [1:0] DIGIT_CNT;
    logic [1:0] STATE_DBG;

    int checks = 0;
    int errors = 0;

    input_unit #(.MAX_DIGITS(3)) dut (
        .CLK(CLK), .RESET(RESET), .DIGIT(DIGIT),
        .KEY_ENTER(KEY_ENTER), .KEY_NEG(KEY_NEG), .KEY_LOAD(KEY_LOAD), .KEY_CLEAR(KEY_CLEAR),
        .TC(TC), .VALID(VALID), .ERR(ERR), .MAG(MAG), .NEG(NEG),
        .DIGIT_CNT(DIGIT_CNT), .STATE_DBG(STATE_DBG)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // keys = {clear, load, enter, neg}; held high for exactly one rising edge.
    task automatic pulse(input logic [3:0] keys, input logic [3:0] d);
        @(negedge CLK);
        DIGIT     = d;
        KEY_CLEAR = keys[3];
        KEY_LOAD  = keys[2];
        KEY_ENTER = keys[1];
        KEY_NEG   = keys[0];
        @(negedge CLK);
        KEY_CLEAR = 1'b0;
        KEY_LOAD  = 1'b0;
        KEY_ENTER = 1'b0;
        KEY_NEG   = 1'b0;
    endtask

    task automatic enter_digit(input logic [3:0] d);
        pulse(4'b0010, d);
    endtask

    task automatic press_neg();
        pulse(4'b0001, 4'd0);
    endtask

    task automatic press_clear();
        pulse(4'b1000, 4'd0);
    endtask

    // Sequence ends on the negedge after the edge that committed; VALID shows one cycle later.
    task automatic load_expect(input string tag, input logic [3:0] keys, input logic exp_valid,
                               input logic [7:0] exp_tc);
        pulse(keys, 4'd5);
        check({tag, "_valid_early"}, VALID, 1'b0);
        @(negedge CLK);
        check({tag, "_valid"}, VALID, exp_valid);
        check({tag, "_tc"}, TC, exp_tc);
        @(negedge CLK);
        check({tag, "_valid_off"}, VALID, 1'b0);
        check({tag, "_tc_hold"}, TC, exp_tc);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_tc", TC, 8'h00);
        check("rst_valid", VALID, 1'b0);
        check("rst_err", ERR, 1'b0);
        check("rst_mag", MAG, 10'd0);
        check("rst_neg", NEG, 1'b0);
        check("rst_cnt", DIGIT_CNT, 2'd0);
        check("rst_state", STATE_DBG, ST_IDLE);
        RESET = 1'b0;

`ifdef INPUT_UNIT_AUTOLOAD_EN
        enter_digit(4'd1);
        enter_digit(4'd0);
        enter_digit(4'd0);
        check("auto_valid_early", VALID, 1'b0);
        @(negedge CLK);
        check("auto_valid", VALID, 1'b1);
        check("auto_tc", TC, 8'h64);
        check("auto_mag", MAG, 10'd0);
        @(negedge CLK);
        check("auto_valid_off", VALID, 1'b0);
        load_expect("auto_explicit", 4'b0100, 1'b1, 8'h00);
`else
        // 127: largest positive operand
        enter_digit(4'd1);
        enter_digit(4'd2);
        enter_digit(4'd7);
        check("p127_mag", MAG, 10'd127);
        check("p127_cnt", DIGIT_CNT, 2'd3);
        load_expect("p127", 4'b0100, 1'b1, 8'h7F);
        check("p127_err", ERR, 1'b0);
        check("p127_mag_clr", MAG, 10'd0);
        check("p127_cnt_clr", DIGIT_CNT, 2'd0);

        // -128 legal, +128 illegal
        enter_digit(4'd1);
        enter_digit(4'd2);
        enter_digit(4'd8);
        press_neg();
        check("m128_neg", NEG, 1'b1);
        load_expect("m128", 4'b0100, 1'b1, 8'h80);
        enter_digit(4'd1);
        enter_digit(4'd2);
        enter_digit(4'd8);
        load_expect("p128", 4'b0100, 1'b0, 8'h80);
        check("p128_err", ERR, 1'b1);
        check("p128_state", STATE_DBG, ST_ERROR);
        press_clear();
        check("p128_clr_err", ERR, 1'b0);
        check("p128_clr_state", STATE_DBG, ST_IDLE);
        check("p128_clr_mag", MAG, 10'd0);

        // odd number of sign toggles
        enter_digit(4'd5);
        press_neg();
        press_neg();
        press_neg();
        load_expect("m5", 4'b0100, 1'b1, 8'hFB);

        // held ENTER produces a single edge
        @(negedge CLK);
        DIGIT = 4'd3;
        KEY_ENTER = 1'b1;
        repeat (10) @(negedge CLK);
        check("hold_mag", MAG, 10'd3);
        check("hold_cnt", DIGIT_CNT, 2'd1);
        KEY_ENTER = 1'b0;
        press_clear();
        check("hold_clr_mag", MAG, 10'd0);

        // full entry ignores the extra digit, then fails the range check
        enter_digit(4'd9);
        enter_digit(4'd9);
        enter_digit(4'd9);
        enter_digit(4'd4);
        check("full_mag", MAG, 10'd999);
        check("full_cnt", DIGIT_CNT, 2'd3);
        load_expect("full", 4'b0100, 1'b0, 8'hFB);
        check("full_err", ERR, 1'b1);
        press_clear();

        // illegal BCD digit; keys other than CLEAR are dead in error
        enter_digit(4'hA);
        check("bcd_err", ERR, 1'b1);
        enter_digit(4'd2);
        check("bcd_err_mag", MAG, 10'd0);
        check("bcd_err_hold", ERR, 1'b1);
        press_clear();
        check("bcd_clr", ERR, 1'b0);

        // LOAD beats ENTER: -42 committed, digit 5 not appended
        enter_digit(4'd4);
        enter_digit(4'd2);
        press_neg();
        load_expect("m42", 4'b0110, 1'b1, 8'hD6);
        check("m42_mag", MAG, 10'd0);

        // CLEAR beats LOAD
        enter_digit(4'd3);
        load_expect("clrload", 4'b1100, 1'b0, 8'hD6);
        check("clrload_mag", MAG, 10'd0);
        check("clrload_state", STATE_DBG, ST_IDLE);
        check("clrload_err", ERR, 1'b0);

        // negative zero commits as 0
        press_neg();
        load_expect("negzero", 4'b0100, 1'b1, 8'h00);
        enter_digit(4'd6);
        load_expect("p6", 4'b0100, 1'b1, 8'h06);
        load_expect("idle_load", 4'b0100, 1'b1, 8'h00);
`endif

        // reset while the commit is pending suppresses VALID
        enter_digit(4'd7);
        pulse(4'b0100, 4'd0);
        #2 RESET = 1'b1;
        #1;
        check("rst_mid_tc", TC, 8'h00);
        check("rst_mid_mag", MAG, 10'd0);
        check("rst_mid_cnt", DIGIT_CNT, 2'd0);
        check("rst_mid_state", STATE_DBG, ST_IDLE);
        @(negedge CLK);
        check("rst_mid_valid", VALID, 1'b0);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_mid_valid2", VALID, 1'b0);
        check("rst_mid_tc2", TC, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
